// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   localparam int unsigned DIV_W     = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_W);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      ZERO = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } div_state_t;

endpackage

// File: rtl/addsub_33bit.sv
// Combinational add/subtract used for the divide step, the final correction and negation.
module addsub_33bit #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   // y = a - b when sub is set, a + b otherwise (modulo 2^W)
   always_comb begin
      y = sub ? (a - b) : (a + b);
   end

endmodule

// File: rtl/div_seq_32bit.sv
// Sequential radix-2 non-restoring divider, signed or unsigned, one quotient bit per cycle.
module div_seq_32bit
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t       r_state;
   div_state_t       w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_rem;      // signed partial remainder, one guard bit
   logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
   logic [WIDTH-1:0] r_dsr;      // divisor magnitude
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_dsr_zero;
   logic [WIDTH:0]   w_shift_r;
   logic [WIDTH:0]   w_add_a;
   logic             w_add_sub;
   logic [WIDTH:0]   w_step;
   logic [WIDTH:0]   w_rem_fix;
   logic [WIDTH:0]   w_neg_q;
   logic [WIDTH:0]   w_neg_r;
   logic [WIDTH-1:0] w_quo_final;
   logic [WIDTH-1:0] w_rem_final;
   logic             w_unused;

   // Operand magnitudes and signs at the start request; most-negative maps to 2^(WIDTH-1)
   always_comb begin
      w_a_neg    = signed_op & dividend[WIDTH-1];
      w_b_neg    = signed_op & divisor[WIDTH-1];
      w_a_mag    = w_a_neg ? (~dividend + ONE) : dividend;
      w_b_mag    = w_b_neg ? (~divisor + ONE) : divisor;
      w_dsr_zero = (divisor == '0);
   end

   // The step adder also performs the FIX correction (R + D) on a negative final remainder
   always_comb begin
      w_shift_r = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
      if (r_state == FIX) begin
         w_add_a   = r_rem;
         w_add_sub = 1'b0;
      end else begin
         w_add_a   = w_shift_r;
         w_add_sub = ~r_rem[WIDTH];
      end
   end

   addsub_33bit #(
      .W (WIDTH + 1)
   ) u_step (
      .a   (w_add_a),
      .b   ({1'b0, r_dsr}),
      .sub (w_add_sub),
      .y   (w_step)
   );

   // Remainder after correction, then sign restoration by 0 - x
   always_comb begin
      w_rem_fix = r_rem[WIDTH] ? w_step : r_rem;
   end

   addsub_33bit #(
      .W (WIDTH + 1)
   ) u_neg_q (
      .a   ('0),
      .b   ({1'b0, r_quo}),
      .sub (1'b1),
      .y   (w_neg_q)
   );

   addsub_33bit #(
      .W (WIDTH + 1)
   ) u_neg_r (
      .a   ('0),
      .b   (w_rem_fix),
      .sub (1'b1),
      .y   (w_neg_r)
   );

   // Final signed results: quotient truncates toward zero, remainder follows the dividend
   always_comb begin
      w_quo_final = r_neg_q ? w_neg_q[WIDTH-1:0] : r_quo;
      w_rem_final = r_neg_r ? w_neg_r[WIDTH-1:0] : w_rem_fix[WIDTH-1:0];
      w_unused    = ^{w_neg_q[WIDTH], w_neg_r[WIDTH]};
   end

   // Next-state and status decode
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = w_dsr_zero ? ZERO : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (r_cnt == LAST_STEP) begin
               w_state_next = FIX;
            end
         end
         ZERO: begin
            busy         = 1'b1;
            w_state_next = DONE;
         end
         FIX: begin
            busy         = 1'b1;
            w_state_next = DONE;
         end
         DONE: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath: operand latch, one shift/add-subtract step per RUN cycle, result write-back
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dsr       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_cnt   <= '0;
                  r_rem   <= '0;
                  r_dsr   <= w_b_mag;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  // Divide-by-zero reports the raw dividend, so keep it unmodified
                  r_quo   <= w_dsr_zero ? dividend : w_a_mag;
               end
            end
            RUN: begin
               r_rem <= w_step;
               r_quo <= {r_quo[WIDTH-2:0], ~w_step[WIDTH]};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            ZERO: begin
               r_quotient  <= '1;
               r_remainder <= r_quo;
               r_dbz       <= 1'b1;
            end
            FIX: begin
               r_quotient  <= w_quo_final;
               r_remainder <= w_rem_final;
               r_dbz       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_32bit.sv
// Self-checking bench for div_seq_32bit: directed cases, handshake, reset abort, random ops.
module tb_div_seq_32bit;

   logic        clk;
   logic        clear_n;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int errors = 0;
   int checks = 0;

   div_seq_32bit #(
      .WIDTH (32)
   ) dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic; signed path in 64 bits so most-negative / -1 cannot trap
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz);
      longint sa, sb, tq, tr;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         tq = sa / sb;
         tr = sa % sb;
         q = tq[31:0]; r = tr[31:0]; dbz = 1'b0;
      end else begin
         q = a / b; r = a % b; dbz = 1'b0;
      end
   endtask

   // One divide: raise start before an edge, count edges until done (edge 1 samples start)
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input int elat, input string tag);
      int k;
      int nbusy;
      logic seen;
      @(negedge clk);
      dividend = a; divisor = b; signed_op = s; start = 1'b1;
      k = 0; nbusy = 0; seen = 1'b0;
      while (!seen && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) begin
            start = 1'b0;
            dividend = ~a;
            divisor = ~b;
            signed_op = ~s;
         end
         if (done) seen = 1'b1;
         else if (busy) nbusy++;
      end
      check({tag, " done_seen"}, 64'(seen), 64'(1));
      check({tag, " latency"}, 64'(k), 64'(elat));
      check({tag, " busy_cycles"}, 64'(nbusy), 64'(elat - 1));
      check({tag, " busy_at_done"}, 64'(busy), 64'(0));
      check({tag, " quotient"}, 64'(quotient), 64'(eq));
      check({tag, " remainder"}, 64'(remainder), 64'(er));
      check({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
      @(posedge clk); #1;
      check({tag, " done_pulse"}, 64'(done), 64'(0));
      check({tag, " q_held"}, 64'(quotient), 64'(eq));
   endtask

   initial begin
      int k;
      int ndone;
      logic [31:0] ra, rb, mq, mr;
      logic rs, mdbz;

      clear_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
      #2;
      check("reset busy", 64'(busy), 64'(0));
      check("reset done", 64'(done), 64'(0));
      check("reset q", 64'(quotient), 64'(0));
      check("reset r", 64'(remainder), 64'(0));
      check("reset dbz", 64'(div_by_zero), 64'(0));
      repeat (2) @(negedge clk);
      clear_n = 1'b1;

      // Directed arithmetic
      do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, "u100_7");
      do_div(-32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, "s-7_2");
      do_div(32'd7, -32'sd2, 1'b1, -32'sd3, 32'd1, 1'b0, 34, "s7_-2");
      do_div(32'hFFFF_FFFF, 32'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 34, "uFF_2");
      do_div(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, "u5_0");
      do_div(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, "s5_0");
      do_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, "dbz_clear");
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, "ovf");

      // Handshake: starts during RUN and in the DONE cycle are ignored
      @(negedge clk);
      dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
      k = 0;
      while (!done && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (k == 1 || k == 6 || k == 21) start = 1'b0;
         if (k == 5 || k == 20) begin
            dividend = 32'd77; divisor = 32'd5; start = 1'b1;
         end
      end
      check("hs latency", 64'(k), 64'(34));
      check("hs quotient", 64'(quotient), 64'(333));
      check("hs remainder", 64'(remainder), 64'(1));
      dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("hs start_in_done busy", 64'(busy), 64'(0));
      @(posedge clk); #1;
      check("hs start_in_done idle", 64'(busy), 64'(0));
      check("hs start_in_done q", 64'(quotient), 64'(333));
      do_div(32'd40, 32'd6, 1'b0, 32'd6, 32'd4, 1'b0, 34, "b2b_a");
      do_div(32'd41, 32'd6, 1'b0, 32'd6, 32'd5, 1'b0, 34, "b2b_b");

      // Reset mid-RUN: leave nonzero results and dbz=1 first
      do_div(32'd123, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd123, 1'b1, 2, "pre_rst");
      @(negedge clk);
      dividend = 32'd100; divisor = 32'd7; signed_op = 1'b0; start = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      clear_n = 1'b0;
      #1;
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      check("rst q", 64'(quotient), 64'(0));
      check("rst r", 64'(remainder), 64'(0));
      check("rst dbz", 64'(div_by_zero), 64'(0));
      @(posedge clk);
      @(negedge clk);
      clear_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("rst no_done", 64'(ndone), 64'(0));
      do_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, "post_rst");

      // Random operands against the arithmetic model
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(1, 255));
            2: rb = -32'($urandom_range(1, 255));
            default: rb = (i % 6 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         endcase
         rs = 1'($urandom_range(0, 1));
         model(ra, rb, rs, mq, mr, mdbz);
         do_div(ra, rb, rs, mq, mr, mdbz, (rb == 32'd0) ? 2 : 34, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
